pll_lock_div_model: RTL

//  Cycle-based simulation model of the GateMate PLL. Replaces the pass-through PLL model.

---
 rtl/pll_lock_div_model.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_div_model.sv
// -----------------------------------------------------------------------------
// pll_lock_div_model
//
// Cycle-based simulation model of the GateMate PLL. A single reference clock
// is divided by DIV into four quadrature phases (0/90/180/270). Lock and
// steady-lock indicators are sequenced by counters rather than tied high.
//
// Ports
//   CLK_REF              in   reference clock, rising edge, the only clock
//   RSTN                 in   asynchronous active-low reset
//   USR_LOCKED_STDY_RST  in   synchronous active-high clear of steady-lock
//   CLK0/90/180/270      out  divided quadrature clocks, registered
//   USR_PLL_LOCKED       out  lock indicator, registered
//   USR_PLL_LOCKED_STDY  out  steady-lock indicator, registered
// -----------------------------------------------------------------------------
module pll_lock_div_model #(
    parameter int   DIV           = 8,
    parameter int   LOCK_CYCLES   = 64,
    parameter int   STEADY_CYCLES = 32,
    parameter logic LOCK_REQ      = 1'b1,
    parameter logic CLK_OUT_EN    = 1'b1,
    parameter logic PLL_EN        = 1'b1
) (
    input  logic CLK_REF,
    input  logic RSTN,
    input  logic USR_LOCKED_STDY_RST,
    output logic CLK0,
    output logic CLK90,
    output logic CLK180,
    output logic CLK270,
    output logic USR_PLL_LOCKED,
    output logic USR_PLL_LOCKED_STDY
);

    localparam int   LW     = $clog2(LOCK_CYCLES + 1);
    localparam int   SW     = $clog2(STEADY_CYCLES + 1);
    localparam int   PW     = $clog2(DIV);
    localparam int   H      = DIV / 2;
    localparam int   Q      = DIV / 4;
    localparam logic CLK_ON = CLK_OUT_EN & PLL_EN;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [LW-1:0]   lock_cnt_r, lock_cnt_s;
    logic [SW-1:0]   stdy_cnt_r, stdy_cnt_s;
    logic [PW-1:0]   ph_r, ph_s;
    logic            run_r, run_s;
    logic            enter_lock_s;
    logic [3:0]      clk_r, clk_s;
    logic            locked_r, stdy_r;

    // A phase is high for the first H positions after its offset, modulo DIV.
    function automatic logic phase_hi(input int ph_i, input int offset);
        return (((ph_i + DIV - offset) % DIV) < H);
    endfunction

    // Next-state logic: lock FSM, counters, divider phase and clock levels.
    always_comb begin
        state_s      = state_r;
        lock_cnt_s   = lock_cnt_r;
        stdy_cnt_s   = stdy_cnt_r;
        enter_lock_s = 1'b0;

        case (state_r)
            ST_OFF: begin
                if (PLL_EN) begin
                    state_s = ST_ACQ;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_ACQ: begin
                lock_cnt_s = lock_cnt_r + LW'(1);
                if (lock_cnt_r == LW'(LOCK_CYCLES - 1)) begin
                    state_s      = ST_LOCKED;
                    enter_lock_s = 1'b1;
                end else begin
                    state_s = ST_ACQ;
                end
            end
            ST_LOCKED: begin
                state_s = ST_LOCKED;
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase

        // Clear request wins over the saturating increment.
        if (USR_LOCKED_STDY_RST) begin
            stdy_cnt_s = {SW{1'b0}};
        end else if ((state_r == ST_LOCKED) && (stdy_cnt_r != SW'(STEADY_CYCLES))) begin
            stdy_cnt_s = stdy_cnt_r + SW'(1);
        end else begin
            stdy_cnt_s = stdy_cnt_r;
        end

        // Without a lock requirement the divider starts on the first edge.
        if (LOCK_REQ) begin
            run_s = run_r | enter_lock_s;
        end else begin
            run_s = 1'b1;
        end

        // The divider restarts at phase 0 on the edge that achieves lock.
        if (LOCK_REQ && enter_lock_s) begin
            ph_s = {PW{1'b0}};
        end else if (run_r) begin
            if (ph_r == PW'(DIV - 1)) begin
                ph_s = {PW{1'b0}};
            end else begin
                ph_s = ph_r + PW'(1);
            end
        end else begin
            ph_s = {PW{1'b0}};
        end

        clk_s[0] = CLK_ON & run_s & phase_hi(int'(ph_s), 0);
        clk_s[1] = CLK_ON & run_s & phase_hi(int'(ph_s), Q);
        clk_s[2] = CLK_ON & run_s & phase_hi(int'(ph_s), H);
        clk_s[3] = CLK_ON & run_s & phase_hi(int'(ph_s), Q + H);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_REF or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_OFF;
            lock_cnt_r <= {LW{1'b0}};
            stdy_cnt_r <= {SW{1'b0}};
            ph_r       <= {PW{1'b0}};
            run_r      <= 1'b0;
            clk_r      <= 4'b0000;
            locked_r   <= 1'b0;
            stdy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
            stdy_cnt_r <= stdy_cnt_s;
            ph_r       <= ph_s;
            run_r      <= run_s;
            clk_r      <= clk_s;
            locked_r   <= (state_s == ST_LOCKED);
            stdy_r     <= (stdy_cnt_s == SW'(STEADY_CYCLES));
        end
    end

    assign CLK0                = clk_r[0];
    assign CLK90               = clk_r[1];
    assign CLK180              = clk_r[2];
    assign CLK270              = clk_r[3];
    assign USR_PLL_LOCKED      = locked_r;
    assign USR_PLL_LOCKED_STDY = stdy_r;

endmodule
